// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage
//   IF/ID pipeline stage with a valid/ready handshake on both sides. Two
//   storage slots keep in_ready purely registered: the main slot drives the
//   decode-side outputs, and the skid slot catches the one extra entry that
//   fetch may present in the cycle that decode stalls. A synchronous flush
//   squashes everything held and leaves a NOP bubble. A saturating counter
//   tracks how many cycles decode held off a valid entry.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous squash of all held entries (wins over accept)
//   in_valid   fetch presents {in_pc, in_instr}
//   in_ready   stage can accept; registered (= !skid_valid)
//   in_pc      next-PC from fetch
//   in_instr   instruction from fetch
//   out_valid  decode-side entry valid
//   out_ready  decode consumes the entry this cycle
//   out_pc     held next-PC
//   out_instr  held instruction, NOP_INSTR when !out_valid
//   occupancy  number of entries held, 0..2
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module ifid_skid_stage #(
    parameter int                 PC_W        = 16,
    parameter int                 INSTR_W     = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = '0,
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]     in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic               main_valid;
    logic [PC_W-1:0]    main_pc;
    logic [INSTR_W-1:0] main_instr;
    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic acc;
    logic deq;
    logic main_load_in;
    logic main_load_skid;
    logic skid_load;
    logic main_valid_nxt;
    logic skid_valid_nxt;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_pc    = main_pc;
    assign out_instr = main_valid ? main_instr : NOP_INSTR;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    assign acc = in_valid && in_ready;
    assign deq = main_valid && out_ready;

    // Load enables are gated by flush so a colliding accept is dropped and
    // the data registers only change on a real load.
    always_comb begin
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (skid_valid) begin
            // acc cannot happen here because in_ready is low
            if (deq) begin
                main_load_skid = 1'b1;
                skid_valid_nxt = 1'b0;
            end
        end else if (!main_valid || deq) begin
            main_load_in   = acc;
            main_valid_nxt = acc;
        end else if (acc) begin
            skid_load      = 1'b1;
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (main_load_in) begin
                main_pc    <= in_pc;
                main_instr <= in_instr;
            end else if (main_load_skid) begin
                main_pc    <= skid_pc;
                main_instr <= skid_instr;
            end
            if (skid_load) begin
                skid_pc    <= in_pc;
                skid_instr <= in_instr;
            end
        end
    end

    // Counts stalled cycles even across a flush; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // A filled skid slot with an empty main slot would reorder entries.
    skid_without_main_a: assert property (@(posedge clk) disable iff (rst)
        main_valid || !skid_valid);

endmodule

// File: tb/tb_ifid_skid_stage.sv
module tb_ifid_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_valid2;
    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] out_pc2;
    logic [15:0] out_instr2;
    logic [1:0]  occupancy2;
    logic [2:0]  stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [15:0] exp_stall;
    logic        pend_push;
    logic [31:0] pend_entry;
    logic        pend_flush;
    logic        pend_stall;
    logic        cccc_seen;

    ifid_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    ifid_skid_stage #(.STALL_CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_pc(16'h0070), .in_instr(16'h7777),
        .out_valid(out_valid2), .out_ready(1'b0), .out_pc(out_pc2), .out_instr(out_instr2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Monitor: compares state against the bench model and pops the
    // scoreboard whenever decode consumes an entry.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            check("occupancy", {62'd0, occupancy}, 64'(exp_q.size()));
            check("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
            check("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
            if (exp_q.size() == 0)
                check("nop_instr", {48'd0, out_instr}, 64'h0);
            if (out_valid && out_instr == 16'hCCCC)
                cccc_seen = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_empty: got pc %0h instr %0h, expected no entry", out_pc, out_instr);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("out_pc", {48'd0, out_pc}, {48'd0, e[31:16]});
                    check("out_instr", {48'd0, out_instr}, {48'd0, e[15:0]});
                end
            end
        end
    end

    // Apply the model effects of the edge just passed, then present the next
    // cycle's inputs and record what the stage should do with them.
    task automatic step(input logic iv, input logic [15:0] pc, input logic [15:0] ins,
                        input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        if (pend_flush) exp_q.delete();
        if (pend_push) exp_q.push_back(pend_entry);
        if (pend_stall && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        in_valid   = iv;
        in_pc      = pc;
        in_instr   = ins;
        out_ready  = ordy;
        flush      = fl;
        pend_push  = iv && (exp_q.size() < 2) && !fl;
        pend_entry = {pc, ins};
        pend_flush = fl;
        pend_stall = (exp_q.size() > 0) && !ordy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_stall  = '0;
        pend_push  = 1'b0;
        pend_flush = 1'b0;
        pend_stall = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'h0);
        check({tag, "_out_instr"}, {48'd0, out_instr}, 64'h0);
        check({tag, "_out_pc"}, {48'd0, out_pc}, 64'h0);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'h1);
        check({tag, "_occupancy"}, {62'd0, occupancy}, 64'h0);
        check({tag, "_stall_cnt"}, {48'd0, stall_cnt}, 64'h0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        cccc_seen = 1'b0;
        clear_model();
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        #1 rst = 1'b0;

        // streaming, one per cycle
        step(1'b1, 16'h0002, 16'h1111, 1'b1, 1'b0);
        step(1'b1, 16'h0004, 16'h2222, 1'b1, 1'b0);
        step(1'b1, 16'h0006, 16'h3333, 1'b1, 1'b0);
        idle(3);

        // backpressure into the skid slot, third offer refused until drained
        step(1'b1, 16'h0010, 16'hA0A0, 1'b0, 1'b0);
        step(1'b1, 16'h0012, 16'hB0B0, 1'b0, 1'b0);
        step(1'b1, 16'h0014, 16'hD0D0, 1'b0, 1'b0);
        step(1'b1, 16'h0014, 16'hD0D0, 1'b0, 1'b0);
        check("skid_full_in_ready", {63'd0, in_ready}, 64'h0);
        check("skid_full_occ", {62'd0, occupancy}, 64'h2);
        step(1'b1, 16'h0014, 16'hD0D0, 1'b1, 1'b0);
        step(1'b1, 16'h0014, 16'hD0D0, 1'b1, 1'b0);
        idle(4);

        // flush with occupancy 2 and an offer pending
        step(1'b1, 16'h0030, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 16'h0032, 16'h5678, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 16'hCCCC, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("post_flush_occ", {62'd0, occupancy}, 64'h0);
        check("post_flush_instr", {48'd0, out_instr}, 64'h0);
        check("post_flush_in_ready", {63'd0, in_ready}, 64'h1);
        // flush colliding with an accept that would otherwise be taken
        step(1'b1, 16'h0040, 16'h4444, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 16'hCCCC, 1'b0, 1'b1);
        // flush colliding with a dequeue: the consumed entry still counts
        step(1'b1, 16'h0050, 16'h5555, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 16'hCCCC, 1'b1, 1'b1);
        // flush while empty
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        idle(3);

        // asynchronous reset in the middle of a cycle with entries held
        step(1'b1, 16'h0060, 16'h6060, 1'b0, 1'b0);
        step(1'b1, 16'h0062, 16'h6262, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("pre_rst_occ", {62'd0, occupancy}, 64'h2);
        #2 rst = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        #1 rst = 1'b0;
        clear_model();
        idle(2);

        // stall counter saturation on a 3-bit instance
        in_valid2 = 1'b1;
        idle(1);
        in_valid2 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            check("sat_stall_cnt", {61'd0, stall_cnt2}, (k < 7) ? 64'(k) : 64'd7);
        end
        check("sat_out_valid", {63'd0, out_valid2}, 64'h1);
        check("sat_out_instr", {48'd0, out_instr2}, 64'h7777);

        // random soak
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'(i),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 5));
        end
        idle(5);
        check("drained", 64'(exp_q.size()), 64'h0);
        check("cccc_never_seen", {63'd0, cccc_seen}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
